// File: rtl/dither_pkg.sv
// -----------------------------------------------------------------------------
// dither_pkg
// Shared definitions for the dither pipeline's output side: default frame
// geometry, the packer state enum and the FIFO entry struct.
//
// Contents:
//   H_PIXELS_DEF / V_PIXELS_DEF / WORD_W_DEF : default frame geometry
//   WORD_W_MAX / ADDR_W_MAX                  : widest word/address an entry holds
//   packer_state_t                           : {SYNC, PACK}
//   packed_word_t                            : {word, addr, last} FIFO entry
// -----------------------------------------------------------------------------
package dither_pkg;

   localparam int H_PIXELS_DEF = 320;
   localparam int V_PIXELS_DEF = 180;
   localparam int WORD_W_DEF   = 16;

   // Entry fields are sized for the widest supported configuration; narrower
   // builds zero-extend into them, and the constant upper bits fold away.
   localparam int WORD_W_MAX = 64;
   localparam int ADDR_W_MAX = 32;

   typedef enum logic {
      SYNC = 1'b0,
      PACK = 1'b1
   } packer_state_t;

   typedef struct packed {
      logic [WORD_W_MAX-1:0] word;
      logic [ADDR_W_MAX-1:0] addr;
      logic                  last;
   } packed_word_t;

endpackage

// File: rtl/dither_packer_if.sv
// -----------------------------------------------------------------------------
// dither_packer_if
// Valid/ready word write port between the packer and the 1-bit frame BRAM.
//
// Signals:
//   word_out       : packed word, bit 0 is the leftmost pixel
//   addr_out       : word address in the frame buffer
//   word_valid_out : word_out/addr_out valid
//   word_ready_in  : sink accepts the word
// Modports:
//   master : the packer (drives word/addr/valid, samples ready)
//   slave  : the frame-buffer writer
// -----------------------------------------------------------------------------
interface dither_packer_if
   import dither_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int ADDR_W = $clog2(H_PIXELS_DEF * V_PIXELS_DEF / WORD_W_DEF)
);

   logic [WORD_W-1:0] word_out;
   logic [ADDR_W-1:0] addr_out;
   logic              word_valid_out;
   logic              word_ready_in;

   modport master (
      output word_out,
      output addr_out,
      output word_valid_out,
      input  word_ready_in
   );

   modport slave (
      input  word_out,
      input  addr_out,
      input  word_valid_out,
      output word_ready_in
   );

endinterface

// File: rtl/packer_fifo2.sv
// -----------------------------------------------------------------------------
// packer_fifo2
// Two-entry FIFO of packed_word_t with a registered head. A pop and a push in
// the same cycle always succeed, even when both slots are occupied.
//
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   push, din      : write request and entry (ignored when full without pop)
//   pop            : read request (ignored when empty)
//   dout           : head entry, straight from a register
//   full, empty    : occupancy flags
// -----------------------------------------------------------------------------
module packer_fifo2
   import dither_pkg::*;
(
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         push,
   input  packed_word_t din,
   input  logic         pop,
   output packed_word_t dout,
   output logic         full,
   output logic         empty
);

   packed_word_t head_q;
   packed_word_t tail_q;
   logic         head_valid_q;
   logic         tail_valid_q;
   logic         do_pop;
   logic         do_push;

   assign do_pop  = pop && head_valid_q;
   assign do_push = push && (!tail_valid_q || do_pop);

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         // NOTE: the data slots are reset too, not just the valid bits,
         // because the head drives word_out/addr_out, which must read 0 out
         // of reset.
         head_q       <= '0;
         tail_q       <= '0;
         head_valid_q <= 1'b0;
         tail_valid_q <= 1'b0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (!head_valid_q) begin
                  head_q       <= din;
                  head_valid_q <= 1'b1;
               end else begin
                  tail_q       <= din;
                  tail_valid_q <= 1'b1;
               end
            end
            2'b01: begin
               head_q       <= tail_q;
               head_valid_q <= tail_valid_q;
               tail_valid_q <= 1'b0;
            end
            2'b11: begin
               // Occupancy is unchanged: the new entry lands behind whatever
               // survives the pop.
               if (tail_valid_q) begin
                  head_q <= tail_q;
                  tail_q <= din;
               end else begin
                  head_q <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = head_q;
   assign full  = tail_valid_q;
   assign empty = !head_valid_q;

endmodule

// File: rtl/dither_packer.sv
// -----------------------------------------------------------------------------
// dither_packer
// Packs the 1-bit dithered pixel stream into WORD_W-bit words (bit 0 =
// leftmost pixel) and offers each word with its frame-buffer word address on
// a valid/ready write port. Packing starts at the first in-range (0,0) pixel.
//
// Ports:
//   clk_in, rst_in       : clock, synchronous active-high reset
//   pixel_valid_in       : pixel tag valid
//   pixel_in             : dithered pixel, 1 = white, 0 = black
//   hcount_in, vcount_in : pixel column / row
//   wr (master)          : word_out, addr_out, word_valid_out, word_ready_in
//   frame_done_out       : pulses in the cycle the frame's last word transfers
//   overflow_out         : sticky, set when a completed word is dropped
//   black_count_out      : black pixels of the last completed frame
//                          (only when PACKER_BLACK_COUNT_EN is defined)
//
// Build option: `define PACKER_BLACK_COUNT_EN adds the black-pixel counter and
// the black_count_out port.
// -----------------------------------------------------------------------------
module dither_packer
   import dither_pkg::*;
#(
   parameter int H_PIXELS = H_PIXELS_DEF,
   parameter int V_PIXELS = V_PIXELS_DEF,
   parameter int WORD_W   = WORD_W_DEF,
   parameter int ADDR_W   = $clog2(H_PIXELS * V_PIXELS / WORD_W)
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   pixel_valid_in,
   input  logic                   pixel_in,
   input  logic [10:0]            hcount_in,
   input  logic [9:0]             vcount_in,
   dither_packer_if.master        wr,
   output logic                   frame_done_out,
   output logic                   overflow_out
`ifdef PACKER_BLACK_COUNT_EN
   ,
   output logic [15:0]            black_count_out
`endif
);

   localparam int          IDX_W  = $clog2(WORD_W);
   localparam logic [10:0] H_LIM  = 11'(H_PIXELS);
   localparam logic [9:0]  V_LIM  = 10'(V_PIXELS);
   localparam logic [10:0] H_LAST = 11'(H_PIXELS - 1);
   localparam logic [9:0]  V_LAST = 10'(V_PIXELS - 1);
   localparam logic [31:0] WPR    = 32'(H_PIXELS / WORD_W);

   packer_state_t      state_q, state_d;
   logic [WORD_W-1:0]  acc_q, acc_d;
   logic [IDX_W-1:0]   idx;
   logic [ADDR_W-1:0]  addr_calc;
   logic               in_range;
   logic               is_origin;
   logic               is_last_px;
   logic               accept;
   logic               complete;

   packed_word_t       pend_q;
   logic               pend_valid_q;
   packed_word_t       head;
   packed_word_t       head_unused;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               drop;

   assign in_range   = pixel_valid_in && (hcount_in < H_LIM) && (vcount_in < V_LIM);
   assign is_origin  = (hcount_in == '0) && (vcount_in == '0);
   assign is_last_px = (hcount_in == H_LAST) && (vcount_in == V_LAST);
   assign idx        = hcount_in[IDX_W-1:0];

   // Constant multiply; the result always fits below the frame's word count.
   assign addr_calc = ADDR_W'(32'(vcount_in) * WPR + 32'(hcount_in[10:IDX_W]));

   // NOTE: every variable written here gets its default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      accept  = in_range && ((state_q == PACK) || is_origin);
      if (accept) begin
         if (is_origin) state_d = PACK;
         if (idx == '0) acc_d = '0;
         acc_d[idx] = pixel_in;
      end
   end

   assign complete = accept && (&idx);

   // A completed word waits one cycle in pend_q before entering the FIFO.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= SYNC;
         acc_q        <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         overflow_out <= 1'b0;
      end else begin
         state_q      <= state_d;
         // Clearing after completion keeps a gap over the next word's bit 0
         // from leaking stale bits into it.
         acc_q        <= complete ? '0 : acc_d;
         pend_valid_q <= complete;
         if (complete) begin
            pend_q.word <= WORD_W_MAX'(acc_d);
            pend_q.addr <= ADDR_W_MAX'(addr_calc);
            pend_q.last <= is_last_px;
         end
         if (drop) overflow_out <= 1'b1;
      end
   end

   assign pop  = wr.word_valid_out && wr.word_ready_in;
   // A pop in the same cycle frees a slot, so only a stalled full FIFO drops.
   assign drop = pend_valid_q && fifo_full && !pop;

   packer_fifo2 u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (pend_valid_q),
      .din    (pend_q),
      .pop    (pop),
      .dout   (head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // Upper entry bits beyond WORD_W/ADDR_W are always zero; sink them here.
   assign head_unused = head;

   assign wr.word_valid_out = !fifo_empty;
   assign wr.word_out       = head.word[WORD_W-1:0];
   assign wr.addr_out       = head.addr[ADDR_W-1:0];
   assign frame_done_out    = pop && head.last;

`ifdef PACKER_BLACK_COUNT_EN
   logic [15:0] black_cnt_q;
   logic [15:0] black_total;

   // Running count including the current pixel, saturating at 0xFFFF.
   always_comb begin
      black_total = black_cnt_q;
      if (!pixel_in && (black_cnt_q != 16'hFFFF)) black_total = black_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         black_cnt_q     <= '0;
         black_count_out <= '0;
      end else if (accept) begin
         if (is_origin) begin
            black_cnt_q <= {15'd0, ~pixel_in};
         end else if (is_last_px) begin
            black_count_out <= black_total;
            black_cnt_q     <= '0;
         end else begin
            black_cnt_q <= black_total;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dither_packer.sv
// -----------------------------------------------------------------------------
// tb_dither_packer
// Directed bench for dither_packer: basic packing and latency, SYNC discard,
// backpressure with drop, full-FIFO push+pop, out-of-range filtering, reset
// mid-frame and a full 320x180 frame. Transfers are recorded by a monitor on
// the falling edge and compared against hand-computed words and addresses.
// -----------------------------------------------------------------------------
module tb_dither_packer;
   import dither_pkg::*;

   localparam int ADDR_W = 12;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        pixel_valid_in = 1'b0;
   logic        pixel_in = 1'b0;
   logic [10:0] hcount_in = '0;
   logic [9:0]  vcount_in = '0;
   logic        frame_done_out;
   logic        overflow_out;
`ifdef PACKER_BLACK_COUNT_EN
   logic [15:0] black_count_out;
`endif

   int n_checks = 0;
   int n_errors = 0;

   dither_packer_if #(.WORD_W(16), .ADDR_W(ADDR_W)) wr ();

   always #5 clk_in = ~clk_in;

   dither_packer dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .pixel_valid_in (pixel_valid_in),
      .pixel_in       (pixel_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .wr             (wr),
      .frame_done_out (frame_done_out),
      .overflow_out   (overflow_out)
`ifdef PACKER_BLACK_COUNT_EN
      ,
      .black_count_out(black_count_out)
`endif
   );

   // Transfer monitor, sampled half a cycle away from the active edge.
   logic [15:0]       q_word[$];
   logic [ADDR_W-1:0] q_addr[$];
   logic              q_done[$];
   int                n_done = 0;

   always @(negedge clk_in) begin
      if (wr.word_valid_out && wr.word_ready_in) begin
         q_word.push_back(wr.word_out);
         q_addr.push_back(wr.addr_out);
         q_done.push_back(frame_done_out);
      end
      if (frame_done_out) n_done++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic pix(input int h, input int v, input logic p, input logic vld = 1'b1);
      pixel_valid_in = vld;
      hcount_in      = 11'(h);
      vcount_in      = 10'(v);
      pixel_in       = p;
      tick();
   endtask

   task automatic idle(input int n);
      pixel_valid_in = 1'b0;
      repeat (n) tick();
   endtask

   task automatic row_word(input int w, input int v, input logic [15:0] pat);
      for (int i = 0; i < 16; i++) pix(w * 16 + i, v, pat[i]);
   endtask

   task automatic do_reset();
      rst_in         = 1'b1;
      pixel_valid_in = 1'b0;
      repeat (2) tick();
      rst_in = 1'b0;
      q_word.delete();
      q_addr.delete();
      q_done.delete();
      n_done = 0;
   endtask

   // Expect exactly the given words at consecutive addresses from 0.
   task automatic expect_words(input string tag, input int n, input logic [15:0] w0,
                               input logic [15:0] w1, input logic [15:0] w2);
      logic [15:0] exp_w [3];
      exp_w[0] = w0;
      exp_w[1] = w1;
      exp_w[2] = w2;
      check({tag, "_count"}, 32'(q_word.size()), 32'(n));
      for (int i = 0; i < n && i < q_word.size(); i++) begin
         check($sformatf("%s_word%0d", tag, i), 32'(q_word[i]), 32'(exp_w[i]));
         check($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(i));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int bad;
      wr.word_ready_in = 1'b1;

      // ---- Reset state ----
      do_reset();
      idle(1);
      check("rst_valid", 32'(wr.word_valid_out), 32'd0);
      check("rst_word", 32'(wr.word_out), 32'd0);
      check("rst_addr", 32'(wr.addr_out), 32'd0);
      check("rst_done", 32'(frame_done_out), 32'd0);
      check("rst_ovf", 32'(overflow_out), 32'd0);
`ifdef PACKER_BLACK_COUNT_EN
      check("rst_black", 32'(black_count_out), 32'd0);
`endif

      // ---- Basic packing: 1,0,1,0... -> 0x5555, valid one cycle late ----
      do_reset();
      wr.word_ready_in = 1'b1;
      row_word(0, 0, 16'h5555);
      check("lat_early_valid", 32'(wr.word_valid_out), 32'd0);
      idle(1);
      check("lat_valid", 32'(wr.word_valid_out), 32'd1);
      check("basic_word", 32'(wr.word_out), 32'h5555);
      check("basic_addr", 32'(wr.addr_out), 32'd0);
      idle(1);
      check("basic_valid_after", 32'(wr.word_valid_out), 32'd0);
      expect_words("basic", 1, 16'h5555, 16'h0, 16'h0);
      check("basic_no_done", 32'(n_done), 32'd0);

      // ---- SYNC discard: row 5 before any (0,0) ----
      do_reset();
      wr.word_ready_in = 1'b1;
      row_word(0, 5, 16'hFFFF);
      row_word(1, 5, 16'hFFFF);
      idle(3);
      check("sync_none", 32'(q_word.size()), 32'd0);
      row_word(0, 0, 16'h8001);
      row_word(1, 0, 16'h00FF);
      idle(3);
      expect_words("sync", 2, 16'h8001, 16'h00FF, 16'h0);

      // ---- Backpressure: third word dropped, head held stable ----
      do_reset();
      wr.word_ready_in = 1'b0;
      row_word(0, 0, 16'hA5C3);
      row_word(1, 0, 16'h0F0F);
      row_word(2, 0, 16'h1234);
      idle(2);
      check("bp_ovf", 32'(overflow_out), 32'd1);
      check("bp_valid", 32'(wr.word_valid_out), 32'd1);
      check("bp_word", 32'(wr.word_out), 32'hA5C3);
      check("bp_addr", 32'(wr.addr_out), 32'd0);
      idle(3);
      check("bp_valid_hold", 32'(wr.word_valid_out), 32'd1);
      check("bp_word_hold", 32'(wr.word_out), 32'hA5C3);
      check("bp_addr_hold", 32'(wr.addr_out), 32'd0);
      wr.word_ready_in = 1'b1;
      idle(4);
      expect_words("bp", 2, 16'hA5C3, 16'h0F0F, 16'h0);
      check("bp_ovf_sticky", 32'(overflow_out), 32'd1);
      check("bp_drained", 32'(wr.word_valid_out), 32'd0);

      // ---- Push into a full FIFO while it pops: nothing dropped ----
      do_reset();
      wr.word_ready_in = 1'b0;
      row_word(0, 0, 16'hA5C3);
      row_word(1, 0, 16'h0F0F);
      row_word(2, 0, 16'h1234);
      wr.word_ready_in = 1'b1;
      idle(5);
      check("fullpp_ovf", 32'(overflow_out), 32'd0);
      expect_words("fullpp", 3, 16'hA5C3, 16'h0F0F, 16'h1234);

      // ---- Out-of-range filtering ----
      do_reset();
      wr.word_ready_in = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [15:0] pat;
         pat = 16'h3C5A;
         pix(i, 0, pat[i]);
         pix(320 + i * 60, 0, ~pat[i]);
         pix(i, 180, ~pat[i]);
         pix(15, 0, 1'b1, 1'b0);
         pix(0, 0, ~pat[i], 1'b0);
      end
      idle(3);
      expect_words("oor", 1, 16'h3C5A, 16'h0, 16'h0);

      // ---- Reset mid-frame: 1 word queued, 7 bits accumulated ----
      do_reset();
      wr.word_ready_in = 1'b0;
      row_word(0, 0, 16'hFFFF);
      for (int i = 0; i < 7; i++) pix(16 + i, 0, 1'b1);
      rst_in         = 1'b1;
      pixel_valid_in = 1'b0;
      tick();
      check("mid_rst_valid", 32'(wr.word_valid_out), 32'd0);
      rst_in = 1'b0;
      wr.word_ready_in = 1'b1;
      row_word(1, 0, 16'hFFFF);
      idle(3);
      check("mid_rst_none", 32'(q_word.size()), 32'd0);
      check("mid_rst_no_done", 32'(n_done), 32'd0);
      check("mid_rst_ovf", 32'(overflow_out), 32'd0);
      row_word(0, 0, 16'h0F0F);
      idle(3);
      expect_words("mid_rst_after", 1, 16'h0F0F, 16'h0, 16'h0);

      // ---- Full 320x180 frame of black pixels ----
      do_reset();
      wr.word_ready_in = 1'b1;
      for (int v = 0; v < 180; v++)
         for (int h = 0; h < 320; h++)
            pix(h, v, 1'b0);
      idle(4);
      check("frame_count", 32'(q_word.size()), 32'd3600);
      bad = 0;
      for (int i = 0; i < q_word.size(); i++)
         if (q_word[i] !== 16'h0 || q_addr[i] !== ADDR_W'(i) || (q_done[i] !== (i == 3599))) bad++;
      check("frame_entries_bad", 32'(bad), 32'd0);
      check("frame_done_pulses", 32'(n_done), 32'd1);
      check("frame_done_last", 32'(q_done.size() == 3600 ? q_done[3599] : 1'b0), 32'd1);
`ifdef PACKER_BLACK_COUNT_EN
      check("frame_black", 32'(black_count_out), 32'd57600);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
